imem_loader: RTL and testbench

- Writer side of the instruction-memory interface. The core only ever reads instruction memory; this block fills it.
- Receives a byte stream over a valid/ready handshake, assembles 16-bit instruction words ({op_code, rs, rt, rd}, high byte first) and writes them sequentially into instruction memory.
- Holds the core in reset via core_hold while loading. Checks a trailing XOR checksum.

---
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader.sv | 144 ++++++++++++++
 tb/tb_imem_loader.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// slave is the loader's view; master is the stream source / memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles {hi,lo} words from a byte stream,
// writes them upward from BASE_ADDR, holds the core in reset and checks an XOR checksum.
//
// state    | meaning
// IDLE     | after reset, waiting for start
// GET_LEN  | waiting for word-count byte (0 = 256 words)
// GET_HI   | waiting for high byte of next word
// GET_LO   | waiting for low byte of next word
// WRITE    | single-cycle memory write of {hi,lo}
// GET_CSUM | waiting for checksum byte
// DONE     | session finished, core released, error valid
module imem_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         core_hold,
  output logic         done,
  output logic         error
);

  typedef enum logic [2:0] {
    IDLE,
    GET_LEN,
    GET_HI,
    GET_LO,
    WRITE,
    GET_CSUM,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic              xfer;
  logic [8:0]        rem;
  logic [7:0]        csum;
  logic [7:0]        hi;
  logic [7:0]        lo;
  logic [ADDR_W-1:0] addr;

  assign xfer           = bus.in_valid & bus.in_ready;
  assign bus.imem_addr  = addr;
  assign bus.imem_wdata = {hi, lo};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    bus.imem_we  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = GET_LEN;
      end
      GET_LEN: begin
        bus.in_ready = 1'b1;
        if (xfer) state_nxt = GET_HI;
      end
      GET_HI: begin
        bus.in_ready = 1'b1;
        if (xfer) state_nxt = GET_LO;
      end
      GET_LO: begin
        bus.in_ready = 1'b1;
        if (xfer) state_nxt = WRITE;
      end
      WRITE: begin
        bus.imem_we = 1'b1;
        state_nxt   = (rem == 9'd1) ? GET_CSUM : GET_HI;
      end
      GET_CSUM: begin
        bus.in_ready = 1'b1;
        if (xfer) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rem counts words still to be written; it is loaded with 256 for a zero length byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem       <= '0;
      csum      <= '0;
      hi        <= '0;
      lo        <= '0;
      addr      <= '0;
      core_hold <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            rem       <= '0;
            csum      <= '0;
            addr      <= BASE_ADDR;
            core_hold <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
          end
        end
        GET_LEN: begin
          if (xfer) rem <= (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
        end
        GET_HI: begin
          if (xfer) begin
            hi   <= bus.in_data;
            csum <= csum ^ bus.in_data;
          end
        end
        GET_LO: begin
          if (xfer) begin
            lo   <= bus.in_data;
            csum <= csum ^ bus.in_data;
          end
        end
        WRITE: begin
          addr <= addr + ADDR_ONE;
          rem  <= rem - 9'd1;
        end
        GET_CSUM: begin
          if (xfer) begin
            error     <= (csum != bus.in_data);
            done      <= 1'b1;
            core_hold <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader; two instances (base 0x00 and 0xFE) see the same stream.
module tb_imem_loader;
  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       start    = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       hold0, done0, err0, hold1, done1, err1;

  int total   = 0;
  int bad     = 0;
  int stuck   = 0;
  int hs_viol = 0;

  logic [23:0] wr0[$];
  logic [23:0] wr1[$];
  logic [23:0] exp0[$];
  logic [23:0] exp1[$];
  logic [15:0] words[$];
  logic [7:0]  good_csum;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(8)) bus0 ();
  imem_loader_if #(.ADDR_W(8)) bus1 ();

  assign bus0.in_data  = in_data;
  assign bus0.in_valid = in_valid;
  assign bus1.in_data  = in_data;
  assign bus1.in_valid = in_valid;

  imem_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .bus(bus0),
    .core_hold(hold0), .done(done0), .error(err0)
  );

  imem_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .bus(bus1),
    .core_hold(hold1), .done(done1), .error(err1)
  );

  // Write capture and handshake watch: while loading, exactly one of in_ready/imem_we is high.
  always @(negedge clk) begin
    if (bus0.imem_we) wr0.push_back({bus0.imem_addr, bus0.imem_wdata});
    if (bus1.imem_we) wr1.push_back({bus1.imem_addr, bus1.imem_wdata});
    if (hold0 && (bus0.in_ready == bus0.imem_we)) hs_viol++;
    if (!hold0 && (bus0.in_ready || bus0.imem_we)) hs_viol++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic make_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(16'($urandom));
  endtask

  // Reference: word i lands at (base + i) mod 256; checksum is XOR of every data byte.
  task automatic build_exp();
    logic [15:0] w;
    exp0.delete();
    exp1.delete();
    good_csum = 8'h00;
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      exp0.push_back({8'(i), w});
      exp1.push_back({8'(254 + i), w});
      good_csum = good_csum ^ w[15:8] ^ w[7:0];
    end
  endtask

  function automatic int pick_idle(input int mode, input bit mid);
    if (mode == 1) return int'($urandom_range(0, 2));
    if (mode == 2) return mid ? 5 : 1;
    return 0;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int idle);
    bit ok;
    ok = 1'b0;
    repeat (idle) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      if (bus0.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) @(posedge clk);
    else stuck++;
    #1 in_valid = 1'b0;
  endtask

  // A junk byte is offered alongside start; it must not be taken as LEN.
  task automatic pulse_start();
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h05;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) stuck++;
  endtask

  task automatic send_stream(input logic [7:0] csum_b, input int mode);
    logic [15:0] w;
    send_byte(8'(words.size()), pick_idle(mode, 1'b0));
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      send_byte(w[15:8], pick_idle(mode, 1'b0));
      send_byte(w[7:0], pick_idle(mode, i == 0));
    end
    send_byte(csum_b, pick_idle(mode, 1'b0));
    wait_done();
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({hold0, done0, err0, bus0.imem_we, bus0.in_ready} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=00000", {hold0, done0, err0, bus0.imem_we, bus0.in_ready});
    end
    total++;
    if ({bus0.imem_addr, bus0.imem_wdata} !== 24'h0) begin
      bad++;
      $display("FAIL reset_bus0 got=%h want=000000", {bus0.imem_addr, bus0.imem_wdata});
    end
    total++;
    if (bus1.imem_addr !== 8'h00) begin
      bad++;
      $display("FAIL reset_addr1 got=%h want=00", bus1.imem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    words.delete();
    words.push_back(16'h1234);
    words.push_back(16'hABCD);
    build_exp();
    wr0.delete();
    wr1.delete();
    stuck = 0;
    total++;
    if (hold0 !== 1'b0) begin
      bad++;
      $display("FAIL basic_hold_before got=%b want=0", hold0);
    end
    pulse_start();
    total++;
    if (hold0 !== 1'b1 || done0 !== 1'b0) begin
      bad++;
      $display("FAIL basic_hold_after_start got=%b%b want=10", hold0, done0);
    end
    send_stream(8'h40, 0);
    total++;
    if (good_csum !== 8'h40) begin
      bad++;
      $display("FAIL basic_model_csum got=%h want=40", good_csum);
    end
    total++;
    if (stuck != 0) begin
      bad++;
      $display("FAIL basic_timeout got=%0d want=0", stuck);
    end
    total++;
    if (wr0.size() != 2) begin
      bad++;
      $display("FAIL basic_count got=%0d want=2", wr0.size());
    end
    for (int i = 0; i < exp0.size(); i++) begin
      total++;
      if (i >= wr0.size() || wr0[i] !== exp0[i]) begin
        bad++;
        $display("FAIL basic_write%0d got=%h want=%h", i, (i < wr0.size()) ? wr0[i] : 24'hx, exp0[i]);
      end
    end
    total++;
    if ({done0, err0, hold0} !== 3'b100) begin
      bad++;
      $display("FAIL basic_status got=%b want=100", {done0, err0, hold0});
    end
  endtask

  task automatic test_bad_csum();
    words.delete();
    words.push_back(16'h1234);
    words.push_back(16'hABCD);
    build_exp();
    wr0.delete();
    stuck = 0;
    pulse_start();
    send_stream(8'h41, 0);
    total++;
    if (stuck != 0 || wr0.size() != 2) begin
      bad++;
      $display("FAIL badcsum_count got=%0d/%0d want=2/0", wr0.size(), stuck);
    end
    for (int i = 0; i < exp0.size(); i++) begin
      total++;
      if (i >= wr0.size() || wr0[i] !== exp0[i]) begin
        bad++;
        $display("FAIL badcsum_write%0d want=%h", i, exp0[i]);
      end
    end
    total++;
    if ({done0, err0, hold0} !== 3'b110) begin
      bad++;
      $display("FAIL badcsum_status got=%b want=110", {done0, err0, hold0});
    end
  endtask

  task automatic test_backpressure();
    words.delete();
    words.push_back(16'h1234);
    words.push_back(16'hABCD);
    build_exp();
    wr0.delete();
    stuck   = 0;
    hs_viol = 0;
    pulse_start();
    send_stream(8'h40, 2);
    total++;
    if (stuck != 0 || wr0.size() != 2) begin
      bad++;
      $display("FAIL bp_count got=%0d/%0d want=2/0", wr0.size(), stuck);
    end
    for (int i = 0; i < exp0.size(); i++) begin
      total++;
      if (i >= wr0.size() || wr0[i] !== exp0[i]) begin
        bad++;
        $display("FAIL bp_write%0d want=%h", i, exp0[i]);
      end
    end
    total++;
    if (hs_viol != 0) begin
      bad++;
      $display("FAIL bp_ready_vs_we got=%0d want=0", hs_viol);
    end
    total++;
    if ({done0, err0} !== 2'b10) begin
      bad++;
      $display("FAIL bp_status got=%b want=10", {done0, err0});
    end
  endtask

  task automatic test_random();
    logic [7:0] csum_b;
    int         errs;
    for (int s = 0; s < 4; s++) begin
      make_words(int'($urandom_range(1, 8)));
      build_exp();
      csum_b = ($urandom_range(0, 1) == 1) ? good_csum : (good_csum ^ 8'(1 << $urandom_range(0, 7)));
      wr0.delete();
      stuck = 0;
      pulse_start();
      total++;
      if (done0 !== 1'b0 || hold0 !== 1'b1) begin
        bad++;
        $display("FAIL rand%0d_restart got=%b%b want=01", s, done0, hold0);
      end
      send_stream(csum_b, 1);
      errs = 0;
      for (int i = 0; i < exp0.size(); i++)
        if (i >= wr0.size() || wr0[i] !== exp0[i]) errs++;
      total++;
      if (errs != 0 || wr0.size() != exp0.size() || stuck != 0) begin
        bad++;
        $display("FAIL rand%0d_writes got=%0d bad of %0d want=0 of %0d", s, errs, wr0.size(), exp0.size());
      end
      total++;
      if (done0 !== 1'b1 || err0 !== (csum_b != good_csum)) begin
        bad++;
        $display("FAIL rand%0d_status got=%b%b want=1%b", s, done0, err0, csum_b != good_csum);
      end
    end
  endtask

  task automatic test_wrap();
    int errs;
    make_words(256);
    build_exp();
    wr0.delete();
    wr1.delete();
    stuck = 0;
    pulse_start();
    send_stream(good_csum, 0);
    total++;
    if (stuck != 0 || wr1.size() != 256) begin
      bad++;
      $display("FAIL wrap_count got=%0d want=256", wr1.size());
    end
    errs = 0;
    for (int i = 0; i < 256; i++)
      if (i >= wr1.size() || wr1[i] !== exp1[i]) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL wrap_writes1 got=%0d wrong want=0", errs);
    end
    total++;
    if (wr1.size() > 2 && (wr1[0][23:16] !== 8'hFE || wr1[2][23:16] !== 8'h00)) begin
      bad++;
      $display("FAIL wrap_addr got=%h,%h want=fe,00", wr1[0][23:16], wr1[2][23:16]);
    end
    total++;
    if (wr0.size() != 256 || wr0[255] !== exp0[255]) begin
      bad++;
      $display("FAIL wrap_writes0 got=%0d want=256", wr0.size());
    end
    total++;
    if ({done1, err1, hold1} !== 3'b100) begin
      bad++;
      $display("FAIL wrap_status got=%b want=100", {done1, err1, hold1});
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] w;
    int          errs;
    make_words(3);
    build_exp();
    wr0.delete();
    stuck = 0;
    pulse_start();
    send_byte(8'd3, 0);
    w = words[0];
    send_byte(w[15:8], 0);
    send_byte(w[7:0], 0);
    w = words[1];
    send_byte(w[15:8], 0);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({hold0, done0, bus0.imem_we, bus0.in_ready} !== 4'b0) begin
      bad++;
      $display("FAIL rstmid_outputs got=%b want=0000", {hold0, done0, bus0.imem_we, bus0.in_ready});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    total++;
    if (wr0.size() != 1 || wr0[0] !== exp0[0]) begin
      bad++;
      $display("FAIL rstmid_partial got=%0d writes want=1", wr0.size());
    end
    make_words(3);
    build_exp();
    wr0.delete();
    pulse_start();
    send_stream(good_csum, 1);
    errs = 0;
    for (int i = 0; i < exp0.size(); i++)
      if (i >= wr0.size() || wr0[i] !== exp0[i]) errs++;
    total++;
    if (errs != 0 || wr0.size() != 3 || stuck != 0) begin
      bad++;
      $display("FAIL rstmid_reload got=%0d wrong of %0d want=0 of 3", errs, wr0.size());
    end
    total++;
    if ({done0, err0} !== 2'b10) begin
      bad++;
      $display("FAIL rstmid_status got=%b want=10", {done0, err0});
    end
  endtask

  task automatic test_start_busy();
    logic [15:0] w;
    int          errs;
    make_words(2);
    build_exp();
    wr0.delete();
    stuck = 0;
    pulse_start();
    send_byte(8'd2, 0);
    w = words[0];
    send_byte(w[15:8], 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (bus0.in_ready !== 1'b1 || hold0 !== 1'b1) begin
      bad++;
      $display("FAIL busy_state got=%b%b want=11", bus0.in_ready, hold0);
    end
    send_byte(w[7:0], 0);
    w = words[1];
    send_byte(w[15:8], 0);
    send_byte(w[7:0], 0);
    send_byte(good_csum, 0);
    wait_done();
    errs = 0;
    for (int i = 0; i < exp0.size(); i++)
      if (i >= wr0.size() || wr0[i] !== exp0[i]) errs++;
    total++;
    if (errs != 0 || wr0.size() != 2 || stuck != 0) begin
      bad++;
      $display("FAIL busy_writes got=%0d wrong of %0d want=0 of 2", errs, wr0.size());
    end
    total++;
    if ({done0, err0} !== 2'b10) begin
      bad++;
      $display("FAIL busy_status got=%b want=10", {done0, err0});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_backpressure();
    test_random();
    test_wrap();
    test_reset_mid();
    test_start_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
